// File: rtl/audio_level_sampler.sv
// audio_level_sampler
//   Peak-hold level detector feeding audio_averaging. Each sample is
//   rectified to a magnitude. The peak is then held over WINDOW samples.
//   At the end of every window the 8-bit peak level is presented together
//   with a one-cycle start flag.
//
// Ports
//   clk                  : system clock
//   rst_n                : asynchronous active-low reset
//   enable               : capture enable; low returns the block to IDLE
//   sample_tick          : sample-rate strobe from a slower, asynchronous
//                          domain; a rising edge means a new sample
//   sample_in            : signed sample, stable for at least 4 clk after
//                          sample_tick rises
//   level_out            : peak level of the last completed window
//   start_averaging_flag : one-cycle pulse; level_out is valid in the same
//                          cycle
//   overrun              : sticky; a tick rise arrived while busy and was
//                          dropped
//
// Handshake: there is no back-pressure. start_averaging_flag is a
// single-cycle valid strobe for level_out. level_out then holds its value
// until the next window completes.
module audio_level_sampler #(
   parameter int WINDOW   = 16,
   parameter int SAMPLE_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                sample_tick,
   input  logic [SAMPLE_W-1:0] sample_in,
   output logic [7:0]          level_out,
   output logic                start_averaging_flag,
   output logic                overrun
);

   localparam int              CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ACCUM = 2'd2,
      EMIT  = 2'd3
   } state_t;

   state_t              state;
   logic                s1, s2, s3;
   logic                tick_rise;
   logic [SAMPLE_W-1:0] sample_reg;
   logic [SAMPLE_W-1:0] neg;
   logic [SAMPLE_W-2:0] mag;
   logic [7:0]          lvl;
   logic [7:0]          peak;
   logic [7:0]          peak_next;
   logic [CNT_W-1:0]    count;

   // s1 is the metastability-catching flop. The edge is detected between
   // s2 and s3, so only settled values are used.
   assign tick_rise = s2 & ~s3;

   // Rectify the captured sample. Only the most-negative code negates back
   // to a negative value. That code saturates to full-scale magnitude.
   assign neg = ~sample_reg + SAMPLE_W'(1);

   always_comb begin
      mag = '0;
      if (!sample_reg[SAMPLE_W-1])
         mag = sample_reg[SAMPLE_W-2:0];
      else if (neg[SAMPLE_W-1])
         mag = '1;
      else
         mag = neg[SAMPLE_W-2:0];
   end

   assign lvl       = mag[SAMPLE_W-2 -: 8];
   assign peak_next = (lvl > peak) ? lvl : peak;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1                   <= 1'b0;
         s2                   <= 1'b0;
         s3                   <= 1'b0;
         state                <= IDLE;
         sample_reg           <= '0;
         peak                 <= '0;
         count                <= '0;
         level_out            <= '0;
         start_averaging_flag <= 1'b0;
         overrun              <= 1'b0;
      end else begin
         s1 <= sample_tick;
         s2 <= s1;
         s3 <= s2;
         if (!enable) begin
            // level_out is deliberately kept so downstream sees a stable value.
            state                <= IDLE;
            peak                 <= '0;
            count                <= '0;
            start_averaging_flag <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= WAIT;
               WAIT: begin
                  if (tick_rise) begin
                     sample_reg <= sample_in;
                     state      <= ACCUM;
                  end
               end
               ACCUM: begin
                  if (tick_rise)
                     overrun <= 1'b1;
                  if (count == LAST) begin
                     level_out            <= peak_next;
                     start_averaging_flag <= 1'b1;
                     state                <= EMIT;
                  end else begin
                     peak  <= peak_next;
                     count <= count + CNT_W'(1);
                     state <= WAIT;
                  end
               end
               EMIT: begin
                  if (tick_rise)
                     overrun <= 1'b1;
                  start_averaging_flag <= 1'b0;
                  peak                 <= '0;
                  count                <= '0;
                  state                <= WAIT;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
